id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core; feeds ALU operands A/B, ALUfun and Sign directly.
- Registers decoded instruction fields and control from ID.
- Resolves EX/MEM and MEM/WB forwarding for rs and rt.
- Detects load-use hazards and inserts bubbles.
- Holds its contents under external stall; clears them on flush.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_fwd_select.sv | 34 +++
 rtl/id_ex_stage.sv | 194 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU function groups, register-zero
// index and the downstream control bundle.
package id_ex_stage_pkg;

  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned REG_ZERO = 0;

  // ALUfun[5:4] selects the ALU unit group
  localparam logic [1:0] ALU_GRP_ADD   = 2'b00;
  localparam logic [1:0] ALU_GRP_LOGIC = 2'b01;
  localparam logic [1:0] ALU_GRP_SHIFT = 2'b10;
  localparam logic [1:0] ALU_GRP_CMP   = 2'b11;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [5:0] alu_fun_code(input logic [1:0] grp, input logic [3:0] op);
    return {grp, op};
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Forwarding mux for one EX source operand; EX/MEM beats MEM/WB, $0 never forwarded.
module id_ex_stage_fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_idx_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_W-1:0]  mem_rd_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_W-1:0]  wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] fwd_c_o
);

  logic mem_hit_c;
  logic wb_hit_c;

  assign mem_hit_c = mem_regwrite_i && (mem_rd_i != REG_W'(REG_ZERO)) && (mem_rd_i == src_idx_i);
  assign wb_hit_c  = wb_regwrite_i  && (wb_rd_i  != REG_W'(REG_ZERO)) && (wb_rd_i  == src_idx_i);

  always_comb begin
    fwd_c_o = reg_data_i;
    if (mem_hit_c) begin
      fwd_c_o = mem_result_i;
    end else if (wb_hit_c) begin
      fwd_c_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// stall hold and flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned FUN_W  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [FUN_W-1:0]   id_alufun,
  input  logic               id_sign,
  input  logic               id_srca_shamt,
  input  logic               id_srcb_imm,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               mem_regwrite,
  input  logic [REG_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_regwrite,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]  wb_result,
  output logic               hazard,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [FUN_W-1:0]   alu_fun,
  output logic               alu_sign,
  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rd,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg
);

  logic               valid_q, valid_d;
  ctrl_t              ctrl_q, ctrl_d;
  ctrl_t              id_ctrl_c;
  logic [REG_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [FUN_W-1:0]   fun_q, fun_d;
  logic               sign_q, sign_d;
  logic               srca_shamt_q, srca_shamt_d;
  logic               srcb_imm_q, srcb_imm_d;
  logic [DATA_W-1:0]  fwd_rs_c, fwd_rt_c;
  logic               hazard_c;

  id_ex_stage_fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .src_idx_i      (rs_q),
    .reg_data_i     (rs_data_q),
    .mem_regwrite_i (mem_regwrite),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .fwd_c_o        (fwd_rs_c)
  );

  id_ex_stage_fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .src_idx_i      (rt_q),
    .reg_data_i     (rt_data_q),
    .mem_regwrite_i (mem_regwrite),
    .mem_rd_i       (mem_rd),
    .mem_result_i   (mem_result),
    .wb_regwrite_i  (wb_regwrite),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_result),
    .fwd_c_o        (fwd_rt_c)
  );

  // Conservative load-use check: matches rt even for instructions that ignore it
  assign hazard_c = !stall && valid_q && ctrl_q.memread && (rd_q != REG_W'(REG_ZERO)) &&
                    id_valid && ((rd_q == id_rs) || (rd_q == id_rt));

  always_comb begin
    id_ctrl_c.regwrite = id_regwrite & id_valid;
    id_ctrl_c.memread  = id_memread  & id_valid;
    id_ctrl_c.memwrite = id_memwrite & id_valid;
    id_ctrl_c.memtoreg = id_memtoreg & id_valid;
  end

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    shamt_d      = shamt_q;
    fun_d        = fun_q;
    sign_d       = sign_q;
    srca_shamt_d = srca_shamt_q;
    srcb_imm_d   = srcb_imm_q;
    if (flush || (!stall && hazard_c)) begin
      // bubble: clear the whole stage so nothing stale can forward or write
      valid_d      = 1'b0;
      ctrl_d       = CTRL_NONE;
      rs_d         = '0;
      rt_d         = '0;
      rd_d         = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      shamt_d      = '0;
      fun_d        = '0;
      sign_d       = 1'b0;
      srca_shamt_d = 1'b0;
      srcb_imm_d   = 1'b0;
    end else if (stall) begin
      // keep forwarded values so a producer retiring mid-stall is not lost
      rs_data_d = fwd_rs_c;
      rt_data_d = fwd_rt_c;
    end else begin
      valid_d      = id_valid;
      ctrl_d       = id_ctrl_c;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      shamt_d      = id_shamt;
      fun_d        = id_alufun;
      sign_d       = id_sign;
      srca_shamt_d = id_srca_shamt;
      srcb_imm_d   = id_srcb_imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= CTRL_NONE;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      fun_q        <= '0;
      sign_q       <= 1'b0;
      srca_shamt_q <= 1'b0;
      srcb_imm_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      shamt_q      <= shamt_d;
      fun_q        <= fun_d;
      sign_q       <= sign_d;
      srca_shamt_q <= srca_shamt_d;
      srcb_imm_q   <= srcb_imm_d;
    end
  end

  assign hazard        = hazard_c;
  assign alu_a         = srca_shamt_q ? DATA_W'(shamt_q) : fwd_rs_c;
  assign alu_b         = srcb_imm_q ? imm_q : fwd_rt_c;
  assign alu_fun       = fun_q;
  assign alu_sign      = sign_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_store_data = fwd_rt_c;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expectations queued as stimulus is driven,
// popped and compared when the stage output is sampled.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
  logic [5:0]  id_alufun;
  logic        id_sign, id_srca_shamt, id_srcb_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard, alu_sign, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_fun;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_srca_shamt(id_srca_shamt), .id_srcb_imm(id_srcb_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard(hazard), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg)
  );

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alufun = '0; id_sign = 0;
    id_srca_shamt = 0; id_srcb_imm = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic clear_fwd();
    mem_regwrite = 0; mem_rd = '0; mem_result = '0;
    wb_regwrite = 0; wb_rd = '0; wb_result = '0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id();
    clear_fwd();

    // reset state
    expect_v("rst_valid", 32'd0);
    expect_v("rst_alu_fun", 32'd0);
    expect_v("rst_hazard", 32'd0);
    expect_v("rst_alu_a", 32'd0);
    #1;
    check(32'(ex_valid)); check(32'(alu_fun)); check(32'(hazard)); check(alu_a);
    tick();
    reset = 0;

    // reset mid-operation, before any clock edge
    id_valid = 1; id_memwrite = 1; id_alufun = alu_fun_code(ALU_GRP_LOGIC, 4'h5);
    expect_v("midrst_pre_valid", 32'd1);
    expect_v("midrst_pre_memwrite", 32'd1);
    tick();
    check(32'(ex_valid)); check(32'(ex_memwrite));
    clear_id();
    reset = 1;
    expect_v("midrst_valid", 32'd0);
    expect_v("midrst_memwrite", 32'd0);
    expect_v("midrst_alu_fun", 32'd0);
    #1;
    check(32'(ex_valid)); check(32'(ex_memwrite)); check(32'(alu_fun));
    reset = 0;

    // forward priority: EX/MEM over MEM/WB over register data
    id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd9; id_regwrite = 1;
    id_rs_data = 32'h99; id_rt_data = 32'h44; id_alufun = alu_fun_code(ALU_GRP_ADD, 4'h0);
    tick();
    clear_id();
    mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'h11;
    wb_regwrite = 1; wb_rd = 5'd3; wb_result = 32'h22;
    expect_v("fwd_mem_wins", 32'h11);
    expect_v("fwd_rt_untouched", 32'h44);
    expect_v("fwd_store_data", 32'h44);
    #1;
    check(alu_a); check(alu_b); check(ex_store_data);
    mem_regwrite = 0;
    expect_v("fwd_wb", 32'h22);
    #1;
    check(alu_a);
    wb_regwrite = 0;
    expect_v("fwd_none", 32'h99);
    #1;
    check(alu_a);
    clear_fwd();

    // register 0 is never forwarded
    id_valid = 1; id_rs = 5'd0; id_rt = 5'd0; id_rt_data = 32'h0;
    id_alufun = alu_fun_code(ALU_GRP_LOGIC, 4'h1);
    tick();
    clear_id();
    mem_regwrite = 1; mem_rd = 5'd0; mem_result = 32'hFFFF;
    wb_regwrite = 1; wb_rd = 5'd0; wb_result = 32'h1234;
    expect_v("r0_alu_b", 32'h0);
    expect_v("r0_store", 32'h0);
    #1;
    check(alu_b); check(ex_store_data);
    clear_fwd();

    // load-use: lw $5 in EX, add $6,$5,$1 in ID
    id_valid = 1; id_rs = 5'd2; id_rd = 5'd5; id_rs_data = 32'h100; id_imm = 32'd8;
    id_srcb_imm = 1; id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
    id_alufun = alu_fun_code(ALU_GRP_ADD, 4'h0);
    tick();
    clear_id();
    id_valid = 1; id_rs = 5'd5; id_rt = 5'd1; id_rd = 5'd6; id_regwrite = 1;
    id_rs_data = 32'hDEAD; id_rt_data = 32'h7;
    expect_v("lu_hazard", 32'd1);
    expect_v("lu_lw_alu_b", 32'd8);
    #1;
    check(32'(hazard)); check(alu_b);
    stall = 1;
    expect_v("lu_hazard_gated_by_stall", 32'd0);
    #1;
    check(32'(hazard));
    stall = 0;
    expect_v("lu_bubble_valid", 32'd0);
    expect_v("lu_bubble_regwrite", 32'd0);
    expect_v("lu_bubble_memread", 32'd0);
    expect_v("lu_bubble_memtoreg", 32'd0);
    expect_v("lu_hazard_after_bubble", 32'd0);
    tick();
    check(32'(ex_valid)); check(32'(ex_regwrite)); check(32'(ex_memread));
    check(32'(ex_memtoreg)); check(32'(hazard));
    mem_regwrite = 1; mem_rd = 5'd5; mem_result = 32'h5A5A;
    tick();
    clear_id();
    mem_regwrite = 0; mem_rd = '0;
    wb_regwrite = 1; wb_rd = 5'd5; wb_result = 32'h5A5A;
    expect_v("lu_add_valid", 32'd1);
    expect_v("lu_add_alu_a_wb_fwd", 32'h5A5A);
    expect_v("lu_add_alu_b", 32'h7);
    expect_v("lu_add_rd", 32'd6);
    #1;
    check(32'(ex_valid)); check(alu_a); check(alu_b); check(32'(ex_rd));
    clear_fwd();

    // stall while the producer of $7 retires through WB
    id_valid = 1; id_rs = 5'd7; id_rt = 5'd8; id_rd = 5'd10; id_regwrite = 1;
    id_rs_data = 32'h0; id_rt_data = 32'h88; id_alufun = alu_fun_code(ALU_GRP_CMP, 4'h3);
    tick();
    clear_id();
    mem_regwrite = 1; mem_rd = 5'd7; mem_result = 32'hCAFE;
    stall = 1;
    expect_v("stall_fwd_mem", 32'hCAFE);
    #1;
    check(alu_a);
    tick();
    clear_fwd();
    wb_regwrite = 1; wb_rd = 5'd7; wb_result = 32'hCAFE;
    tick();
    clear_fwd();
    tick();
    stall = 0;
    expect_v("stall_keeps_producer", 32'hCAFE);
    expect_v("stall_alu_b", 32'h88);
    expect_v("stall_valid_held", 32'd1);
    expect_v("stall_alu_fun_held", 32'h33);
    #1;
    check(alu_a); check(alu_b); check(32'(ex_valid)); check(32'(alu_fun));

    // shift amount and immediate operand paths, then flush
    id_valid = 1; id_srca_shamt = 1; id_shamt = 5'd4; id_srcb_imm = 1;
    id_imm = 32'hFFFF_FFF0; id_rs_data = 32'h123; id_regwrite = 1; id_sign = 1;
    id_alufun = alu_fun_code(ALU_GRP_SHIFT, 4'h0);
    expect_v("sh_alu_a", 32'd4);
    expect_v("sh_alu_b", 32'hFFFF_FFF0);
    expect_v("sh_alu_fun", 32'h20);
    expect_v("sh_alu_sign", 32'd1);
    tick();
    check(alu_a); check(alu_b); check(32'(alu_fun)); check(32'(alu_sign));
    flush = 1;
    expect_v("flush_valid", 32'd0);
    expect_v("flush_regwrite", 32'd0);
    tick();
    check(32'(ex_valid)); check(32'(ex_regwrite));
    flush = 0;

    // flush beats stall
    expect_v("fs_pre_valid", 32'd1);
    tick();
    check(32'(ex_valid));
    flush = 1; stall = 1;
    expect_v("flush_over_stall", 32'd0);
    tick();
    check(32'(ex_valid));
    flush = 0; stall = 0;
    clear_id();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
